// File: rtl/stream_demux_if.sv
// Stream demux bus: one producer-side stream in, N_OUT consumer-side streams out.
// Latency: n/a (wiring only).
// Backpressure: s_ready toward the producer, m_ready per channel from the consumers.
//
// Signals
//   s_valid/s_ready/s_data/s_last/s_sel : single input stream with destination index
//   m_valid/m_ready/m_data/m_last       : per-channel outputs, channel k data at [k*DATA_W +: DATA_W]
// Modports
//   slave  : the demux itself (consumes s_*, drives s_ready and m_*)
//   master : the surrounding producer/consumers (drives s_* and m_ready)
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4
);
  localparam int SEL_W = $clog2(N_OUT);

  logic                      s_valid;
  logic                      s_ready;
  logic [DATA_W-1:0]         s_data;
  logic                      s_last;
  logic [SEL_W-1:0]          s_sel;
  logic [N_OUT-1:0]          m_valid;
  logic [N_OUT-1:0]          m_ready;
  logic [N_OUT*DATA_W-1:0]   m_data;
  logic [N_OUT-1:0]          m_last;

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, s_last, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N_OUT stream demultiplexer; optional per-packet select latching.
// Latency: 1 cycle from accepted input beat to output valid on the chosen channel.
// Backpressure: s_ready follows the target channel's register (drain+load same cycle); invalid targets always accept and drop.
//
// Ports
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : stream_demux_if.slave carrying the input stream and all output channels
//   drop_cnt   : saturating count of beats consumed with an out-of-range select
module stream_demux #(
  parameter int DATA_W   = 8,
  parameter int N_OUT    = 4,
  parameter int PKT_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_demux_if.slave   bus,
  output logic [15:0]     drop_cnt
);

  localparam int SEL_W = $clog2(N_OUT);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]        state_q;
  logic [SEL_W-1:0]  sel_q;
  logic [N_OUT-1:0]  vld_q;
  logic [N_OUT-1:0]  last_q;
  logic [DATA_W-1:0] dat_q [N_OUT];
  logic [15:0]       drop_q;

  logic [SEL_W-1:0]  tgt;
  logic              tgt_ok;
  logic [N_OUT-1:0]  can_load;
  logic [N_OUT-1:0]  load;
  logic              rdy;
  logic              acc;
  logic              drop;

  // Mid-packet the latched select wins; otherwise each beat routes by its own s_sel.
  assign tgt      = ((PKT_MODE != 0) && (state_q == ST_BUSY)) ? sel_q : bus.s_sel;
  assign tgt_ok   = (int'(tgt) < N_OUT);
  assign can_load = ~vld_q | bus.m_ready;

  // Out-of-range targets take the drop path, which never stalls.
  always_comb begin
    rdy = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (tgt == SEL_W'(k)) rdy = can_load[k];
    end
    rdy = rdy & rst_n;
  end

  assign bus.s_ready = rdy;
  assign acc         = bus.s_valid && rdy;
  assign drop        = acc && !tgt_ok;

  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (acc && (tgt == SEL_W'(k))) load[k] = 1'b1;
    end
  end

  // Per-channel output registers; data/last hold their value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int k = 0; k < N_OUT; k++) dat_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          vld_q[k]  <= 1'b1;
          dat_q[k]  <= bus.s_data;
          last_q[k] <= bus.s_last;
        end else if (bus.m_ready[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Packet tracking; a single-beat packet never leaves IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else if ((PKT_MODE != 0) && acc) begin
      if ((state_q == ST_IDLE) && !bus.s_last) begin
        state_q <= ST_BUSY;
        sel_q   <= bus.s_sel;
      end else if ((state_q == ST_BUSY) && bus.s_last) begin
        state_q <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt    = drop_q;
  assign bus.m_valid = vld_q;
  assign bus.m_last  = last_q;

  always_comb begin
    bus.m_data = '0;
    for (int k = 0; k < N_OUT; k++) bus.m_data[k*DATA_W +: DATA_W] = dat_q[k];
  end

endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux: three instances (per-beat N=4, packet N=4, packet N=3 with drops).
// Latency: a queue-based reference model checks every cycle; directed sequences check fixed values.
// Backpressure: random m_ready; the producer holds its beat while s_valid && !s_ready.
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  stream_demux_if #(.DATA_W(8), .N_OUT(4)) if0 ();
  stream_demux_if #(.DATA_W(8), .N_OUT(4)) if1 ();
  stream_demux_if #(.DATA_W(8), .N_OUT(3)) if2 ();
  logic [15:0] dc0, dc1, dc2;

  stream_demux #(.DATA_W(8), .N_OUT(4), .PKT_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .drop_cnt(dc0));
  stream_demux #(.DATA_W(8), .N_OUT(4), .PKT_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .drop_cnt(dc1));
  stream_demux #(.DATA_W(8), .N_OUT(3), .PKT_MODE(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .drop_cnt(dc2));

  // Stimulus per instance
  logic       sv [3];
  logic [7:0] sd [3];
  logic       sl [3];
  logic [1:0] ss [3];
  logic [3:0] mr [3];

  // Observed outputs, padded to four channels
  logic            sr [3];
  logic [3:0]      mv [3];
  logic [3:0]      ml [3];
  logic [3:0][7:0] md [3];
  logic [15:0]     dc [3];

  assign if0.s_valid = sv[0]; assign if0.s_data = sd[0]; assign if0.s_last = sl[0];
  assign if0.s_sel   = ss[0]; assign if0.m_ready = mr[0];
  assign if1.s_valid = sv[1]; assign if1.s_data = sd[1]; assign if1.s_last = sl[1];
  assign if1.s_sel   = ss[1]; assign if1.m_ready = mr[1];
  assign if2.s_valid = sv[2]; assign if2.s_data = sd[2]; assign if2.s_last = sl[2];
  assign if2.s_sel   = ss[2]; assign if2.m_ready = mr[2][2:0];

  assign sr[0] = if0.s_ready; assign mv[0] = if0.m_valid; assign ml[0] = if0.m_last; assign md[0] = if0.m_data;
  assign sr[1] = if1.s_ready; assign mv[1] = if1.m_valid; assign ml[1] = if1.m_last; assign md[1] = if1.m_data;
  assign sr[2] = if2.s_ready; assign mv[2] = {1'b0, if2.m_valid}; assign ml[2] = {1'b0, if2.m_last};
  assign md[2] = {8'h00, if2.m_data};
  assign dc[0] = dc0; assign dc[1] = dc1; assign dc[2] = dc2;

  // Reference model: per channel a FIFO of {last,data}, packet state, drop count.
  typedef logic [8:0] beat_t;
  beat_t q [12][$];
  int   nout [3] = '{4, 4, 3};
  int   pkm  [3] = '{0, 1, 1};
  bit   in_pkt [3];
  logic [1:0] psel [3];
  int   drops [3];
  bit   hold [3];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle(input int d);
    int t;
    bit er;
    beat_t b;
    t  = (pkm[d] != 0 && in_pkt[d]) ? int'(psel[d]) : int'(ss[d]);
    er = (t >= nout[d]) || (q[d*4+t].size() == 0) || mr[d][t];
    chk($sformatf("d%0d_s_ready", d), 32'(sr[d]), 32'(er));
    chk($sformatf("d%0d_drop_cnt", d), 32'(dc[d]), 32'(drops[d]));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("d%0d_m_valid%0d", d, k), 32'(mv[d][k]),
          32'((k < nout[d]) && (q[d*4+k].size() != 0)));
      if (mv[d][k] && mr[d][k] && q[d*4+k].size() != 0) begin
        b = q[d*4+k].pop_front();
        chk($sformatf("d%0d_m_data%0d", d, k), 32'(md[d][k]), 32'(b[7:0]));
        chk($sformatf("d%0d_m_last%0d", d, k), 32'(ml[d][k]), 32'(b[8]));
      end
    end
    hold[d] = sv[d] && !sr[d];
    if (sv[d] && sr[d]) begin
      if (t < nout[d]) q[d*4+t].push_back({sl[d], sd[d]});
      else if (drops[d] < 65535) drops[d]++;
      if (pkm[d] != 0) begin
        if (!in_pkt[d] && !sl[d]) begin
          in_pkt[d] = 1'b1;
          psel[d]   = ss[d];
        end else if (in_pkt[d] && sl[d]) begin
          in_pkt[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++) model_cycle(d);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive(input int d);
    if (!hold[d]) begin
      sv[d] = ($urandom_range(0, 3) != 0);
      ss[d] = 2'($urandom_range(0, 3));
      sd[d] = 8'($urandom);
      sl[d] = 1'($urandom_range(0, 1));
    end
    mr[d] = 4'($urandom);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 12; i++) q[i].delete();
    for (int d = 0; d < 3; d++) begin
      in_pkt[d] = 1'b0; psel[d] = 2'd0; drops[d] = 0; hold[d] = 1'b0;
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      sv[d] = 1'b0; mr[d] = 4'hF;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      sv[d] = 1'b0; sd[d] = 8'h00; sl[d] = 1'b0; ss[d] = 2'd0; mr[d] = 4'hF;
    end
    model_clear();
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_s_ready%0d", d), 32'(sr[d]), 32'd0);
      chk($sformatf("rst_m_valid%0d", d), 32'(mv[d]), 32'd0);
      chk($sformatf("rst_m_last%0d", d), 32'(ml[d]), 32'd0);
      chk($sformatf("rst_m_data%0d", d), 32'(md[d]), 32'd0);
      chk($sformatf("rst_drop%0d", d), 32'(dc[d]), 32'd0);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // One beat per channel, all consumers ready
    for (int i = 0; i < 4; i++) begin
      sv[0] = 1'b1; ss[0] = 2'(i); sd[0] = 8'(8'hA0 + i); sl[0] = 1'b0;
      tick();
      chk("t1_m_valid", 32'(mv[0]), 32'(1 << i));
      chk("t1_m_data", 32'(md[0][i]), 32'(8'hA0 + i));
    end
    sv[0] = 1'b0;
    tick();

    // Channel 2 stalled: holds 55, other channel still flows, second beat waits
    mr[0] = 4'b1011;
    sv[0] = 1'b1; ss[0] = 2'd2; sd[0] = 8'h55; sl[0] = 1'b0;
    tick();
    chk("t2_hold_vld", 32'(mv[0][2]), 32'd1);
    chk("t2_hold_dat", 32'(md[0][2]), 32'h55);
    ss[0] = 2'd1; sd[0] = 8'h11; #1;
    chk("t3_rdy_other", 32'(sr[0]), 32'd1);
    tick();
    chk("t3_ch1_vld", 32'(mv[0][1]), 32'd1);
    chk("t3_ch1_dat", 32'(md[0][1]), 32'h11);
    chk("t3_ch2_kept", 32'(md[0][2]), 32'h55);
    ss[0] = 2'd2; sd[0] = 8'h66; #1;
    chk("t2_rdy_blocked", 32'(sr[0]), 32'd0);
    tick();
    tick();
    chk("t2_still_55", 32'(md[0][2]), 32'h55);
    mr[0] = 4'hF; #1;
    chk("t2_rdy_drain", 32'(sr[0]), 32'd1);
    tick();
    chk("t2_now_66", 32'(md[0][2]), 32'h66);
    chk("t2_66_vld", 32'(mv[0][2]), 32'd1);
    sv[0] = 1'b0;
    tick();
    chk("t2_drained", 32'(mv[0][2]), 32'd0);

    // Packet mode: select latched on first beat
    for (int i = 0; i < 3; i++) begin
      sv[1] = 1'b1; ss[1] = (i == 0) ? 2'd3 : 2'd0; sd[1] = 8'(8'hC1 + i); sl[1] = (i == 2);
      tick();
      chk("t4_m_valid", 32'(mv[1]), 32'h8);
      chk("t4_m_data", 32'(md[1][3]), 32'(8'hC1 + i));
      chk("t4_m_last", 32'(ml[1][3]), 32'(i == 2));
    end
    ss[1] = 2'd0; sd[1] = 8'hC4; sl[1] = 1'b1;
    tick();
    chk("t4_next_pkt", 32'(mv[1]), 32'h1);
    sv[1] = 1'b0;
    tick();

    // Drops on the 3-channel instance, then saturation
    sv[2] = 1'b1; ss[2] = 2'd3; sl[2] = 1'b1; sd[2] = 8'h5A; #1;
    chk("t5_rdy", 32'(sr[2]), 32'd1);
    tick();
    chk("t5_drop1", 32'(dc[2]), 32'd1);
    chk("t5_no_out", 32'(mv[2]), 32'd0);
    tick();
    chk("t5_drop2", 32'(dc[2]), 32'd2);
    repeat (65540) begin
      sd[2] = 8'($urandom);
      rand_drive(0);
      rand_drive(1);
      tick();
    end
    chk("t5_sat", 32'(dc[2]), 32'hFFFF);
    tick();
    chk("t5_sat_hold", 32'(dc[2]), 32'hFFFF);

    repeat (2000) begin
      for (int d = 0; d < 3; d++) rand_drive(d);
      tick();
    end

    // Reset in the middle of a packet with channels full
    idle_all();
    tick();
    tick();
    mr[1] = 4'h0; sv[1] = 1'b1; ss[1] = 2'd1; sd[1] = 8'hD1; sl[1] = 1'b0;
    mr[0] = 4'h0; sv[0] = 1'b1; ss[0] = 2'd0; sd[0] = 8'h77; sl[0] = 1'b0;
    tick();
    sd[1] = 8'hD2;
    sv[0] = 1'b0;
    tick();
    chk("t6_pre_full1", 32'(mv[1][1]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("t6_m_valid%0d", d), 32'(mv[d]), 32'd0);
      chk($sformatf("t6_drop%0d", d), 32'(dc[d]), 32'd0);
      chk($sformatf("t6_s_ready%0d", d), 32'(sr[d]), 32'd0);
    end
    model_clear();
    idle_all();
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    sv[1] = 1'b1; ss[1] = 2'd2; sd[1] = 8'hE1; sl[1] = 1'b0;
    tick();
    chk("t6_fresh_sel", 32'(mv[1]), 32'h4);
    chk("t6_fresh_dat", 32'(md[1][2]), 32'hE1);
    ss[1] = 2'd3; sd[1] = 8'hE2; sl[1] = 1'b1;
    tick();
    chk("t6_held_sel", 32'(mv[1]), 32'h4);
    chk("t6_held_dat", 32'(md[1][2]), 32'hE2);
    chk("t6_held_last", 32'(ml[1][2]), 32'd1);
    sv[1] = 1'b0;
    tick();

    repeat (1500) begin
      for (int d = 0; d < 3; d++) rand_drive(d);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
